// File: rtl/ddu_pkg.sv
// Shared types and constants for the debug/display unit.
// Run-FSM states and active-low 7-segment hex table.
package ddu_pkg;

   typedef enum logic [1:0] {
      PAUSE = 2'd0,
      STEP  = 2'd1,
      RUN   = 2'd2
   } run_st_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // {g..a}, active-low
   localparam logic [6:0] SEG_HEX [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      return SEG_HEX[n];
   endfunction

endpackage

// File: rtl/ddu_debounce.sv
// Two-flop synchroniser, counting debouncer and rising-edge pulse.
// Edges held through reset are discarded until a release is seen.
module ddu_debounce
   import ddu_pkg::*;
#(
   parameter int DEB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          s1;
   logic          s2;
   logic          v1;
   logic          v2;
   logic          armed;
   logic [CW-1:0] cnt;
   logic          term;

   assign term = (cnt == CW'(DEB_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         v1    <= 1'b0;
         v2    <= 1'b0;
         armed <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         v1 <= 1'b1;
         v2 <= v1;
         // arm only once a genuine released sample has passed the synchroniser
         if (v2 && !s2)
            armed <= 1'b1;
         if (s2 != level) begin
            if (term) begin
               level <= s2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign rise = armed & s2 & ~level & term;

endmodule

// File: rtl/ddu_ctrl.sv
// Debug/display unit: run gating, debug address stepping and 7-seg scan.
// Optional DDU_AUTOREPEAT_EN: held inc/dec buttons auto-repeat.
module ddu_ctrl
   import ddu_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 8,
   parameter int PC_W       = 32,
   parameter int LED_W      = 16,
   parameter int DEB_CYCLES = 50000,
   parameter int SCAN_DIV   = 50000,
   parameter int REPEAT_CYC = 5000000,
   localparam int DIGITS    = DATA_W / 4
) (
   input  logic              clk_500,
   input  logic              rst_n,
   input  logic              cont,
   input  logic              step,
   input  logic              mem,
   input  logic              inc,
   input  logic              dec,
   input  logic [DATA_W-1:0] reg_data,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [PC_W-1:0]   pc,
   output logic              run,
   output logic [ADDR_W-1:0] addr,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg,
   output logic [LED_W-1:0]  led
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic cont_lv, cont_rise;
   logic step_lv, step_rise;
   logic mem_lv,  mem_rise;
   logic inc_lv,  inc_rise;
   logic dec_lv,  dec_rise;

   ddu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_cont (
      .clk(clk_500), .rst_n(rst_n), .raw(cont),
      .level(cont_lv), .rise(cont_rise)
   );
   ddu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_step (
      .clk(clk_500), .rst_n(rst_n), .raw(step),
      .level(step_lv), .rise(step_rise)
   );
   ddu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_mem (
      .clk(clk_500), .rst_n(rst_n), .raw(mem),
      .level(mem_lv), .rise(mem_rise)
   );
   ddu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_inc (
      .clk(clk_500), .rst_n(rst_n), .raw(inc),
      .level(inc_lv), .rise(inc_rise)
   );
   ddu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_dec (
      .clk(clk_500), .rst_n(rst_n), .raw(dec),
      .level(dec_lv), .rise(dec_rise)
   );

   run_st_t state, nxt;

   always_ff @(posedge clk_500) begin
      if (!rst_n) begin
         state <= PAUSE;
         run   <= 1'b0;
      end else begin
         state <= nxt;
         run   <= (nxt != PAUSE);
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         PAUSE: begin
            if (cont_lv)
               nxt = RUN;
            else if (step_rise)
               nxt = STEP;
         end
         STEP: nxt = PAUSE;
         RUN: begin
            if (!cont_lv)
               nxt = PAUSE;
         end
         default: nxt = PAUSE;
      endcase
   end

   logic inc_rep;
   logic dec_rep;

`ifdef DDU_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_CYC);
   localparam int RP = REPEAT_CYC / 8;

   logic [RW-1:0] inc_rc;
   logic [RW-1:0] dec_rc;

   // first repeat REPEAT_CYC after the press, then every REPEAT_CYC/8
   always_ff @(posedge clk_500) begin
      if (!rst_n || inc_rise || !inc_lv)
         inc_rc <= '0;
      else if (inc_rc == RW'(REPEAT_CYC - 1))
         inc_rc <= RW'(REPEAT_CYC - RP);
      else
         inc_rc <= inc_rc + 1'b1;
   end

   always_ff @(posedge clk_500) begin
      if (!rst_n || dec_rise || !dec_lv)
         dec_rc <= '0;
      else if (dec_rc == RW'(REPEAT_CYC - 1))
         dec_rc <= RW'(REPEAT_CYC - RP);
      else
         dec_rc <= dec_rc + 1'b1;
   end

   assign inc_rep = inc_lv & ~dec_lv & (inc_rc == RW'(REPEAT_CYC - 1));
   assign dec_rep = dec_lv & ~inc_lv & (dec_rc == RW'(REPEAT_CYC - 1));
`else
   assign inc_rep = 1'b0;
   assign dec_rep = 1'b0;
`endif

   logic up;
   logic dn;

   assign up = inc_rise | inc_rep;
   assign dn = dec_rise | dec_rep;

   always_ff @(posedge clk_500) begin
      if (!rst_n)
         addr <= '0;
      else if (up && !dn)
         addr <= addr + 1'b1;
      else if (dn && !up)
         addr <= addr - 1'b1;
   end

   logic [SW-1:0]     sc;
   logic [IW-1:0]     idx;
   logic [DATA_W-1:0] sel;
   logic [3:0]        nib;

   assign sel = mem_lv ? mem_data : reg_data;
   assign nib = sel[idx*4 +: 4];

   always_ff @(posedge clk_500) begin
      if (!rst_n) begin
         sc  <= '0;
         idx <= '0;
         an  <= '1;
         seg <= SEG_BLANK;
      end else begin
         if (sc == SW'(SCAN_DIV - 1)) begin
            sc  <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            sc <= sc + 1'b1;
         end
         an  <= ~(DIGITS'(1) << idx);
         seg <= hex_seg(nib);
      end
   end

   assign led = {addr, pc[LED_W-ADDR_W+1:2]};

   // switch edges and out-of-window PC bits have no consumer here
   logic unused_ok;
   assign unused_ok = ^{cont_rise, mem_rise, step_lv,
                        pc[PC_W-1:LED_W-ADDR_W+2], pc[1:0]};

endmodule

// File: tb/tb_ddu_ctrl.sv
// Directed self-checking bench for ddu_ctrl.
// Short debounce/scan/repeat parameters keep runs brief.
module tb_ddu_ctrl;
   import ddu_pkg::*;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;
   localparam int PC_W   = 32;
   localparam int LED_W  = 16;
   localparam int DIGITS = DATA_W / 4;

   logic              clk_500 = 1'b0;
   logic              rst_n   = 1'b0;
   logic              cont    = 1'b0;
   logic              step    = 1'b0;
   logic              mem     = 1'b0;
   logic              inc     = 1'b0;
   logic              dec     = 1'b0;
   logic [DATA_W-1:0] reg_data = '0;
   logic [DATA_W-1:0] mem_data = '0;
   logic [PC_W-1:0]   pc       = '0;
   logic              run;
   logic [ADDR_W-1:0] addr;
   logic [DIGITS-1:0] an;
   logic [6:0]        seg;
   logic [LED_W-1:0]  led;

   int nvec = 0;
   int nerr = 0;
   logic [ADDR_W-1:0] exp_addr;

   ddu_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .LED_W(LED_W),
      .DEB_CYCLES(4), .SCAN_DIV(4), .REPEAT_CYC(32)
   ) dut (
      .clk_500(clk_500), .rst_n(rst_n), .cont(cont), .step(step),
      .mem(mem), .inc(inc), .dec(dec), .reg_data(reg_data),
      .mem_data(mem_data), .pc(pc), .run(run), .addr(addr),
      .an(an), .seg(seg), .led(led)
   );

   always #5 clk_500 = ~clk_500;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_500);
         #1;
      end
   endtask

   task automatic test_reset;
      bit ok;
      rst_n = 1'b0;
      tick(2);
      nvec++;
      if (run !== 1'b0) begin
         nerr++;
         $display("FAIL reset_run got %b want 0", run);
      end
      nvec++;
      if (addr !== 8'h00) begin
         nerr++;
         $display("FAIL reset_addr got %h want 00", addr);
      end
      nvec++;
      if (an !== 8'hFF) begin
         nerr++;
         $display("FAIL reset_an got %h want FF", an);
      end
      nvec++;
      if (seg !== 7'h7F) begin
         nerr++;
         $display("FAIL reset_seg got %h want 7F", seg);
      end
      rst_n = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         if (an === 8'hFE)
            ok = 1'b1;
      end
      nvec++;
      if (!ok) begin
         nerr++;
         $display("FAIL reset_an_release got %h want FE", an);
      end
      tick(10);
   endtask

   task automatic test_step;
      int cnt;
      int first;
      cnt = 0;
      first = -1;
      step = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         tick(1);
         if (k == 10)
            step = 1'b0;
         if (run === 1'b1) begin
            cnt++;
            if (first < 0)
               first = k;
         end
      end
      nvec++;
      if (cnt != 1) begin
         nerr++;
         $display("FAIL step_count got %0d want 1", cnt);
      end
      nvec++;
      if (first != 6) begin
         nerr++;
         $display("FAIL step_latency got %0d want 6", first);
      end
   endtask

   task automatic test_bounce;
      int cnt;
      cnt = 0;
      step = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         if (k == 3)
            step = 1'b0;
         if (run === 1'b1)
            cnt++;
      end
      nvec++;
      if (cnt != 0) begin
         nerr++;
         $display("FAIL bounce_run got %0d want 0", cnt);
      end
   endtask

   task automatic test_reset_mid_press;
      int cnt;
      step = 1'b1;
      tick(3);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 15; k++) begin
         tick(1);
         if (run === 1'b1)
            cnt++;
      end
      step = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick(1);
         if (run === 1'b1)
            cnt++;
      end
      nvec++;
      if (cnt != 0) begin
         nerr++;
         $display("FAIL held_reset_run got %0d want 0", cnt);
      end
      test_step();
   endtask

   task automatic test_free_run;
      int lows;
      cont = 1'b1;
      tick(6);
      nvec++;
      if (run !== 1'b0) begin
         nerr++;
         $display("FAIL freerun_early got %b want 0", run);
      end
      lows = 0;
      for (int k = 7; k <= 30; k++) begin
         tick(1);
         step = (k >= 10 && k < 20);
         if (run !== 1'b1)
            lows++;
      end
      step = 1'b0;
      nvec++;
      if (lows != 0) begin
         nerr++;
         $display("FAIL freerun_hold got %0d low cycles want 0", lows);
      end
      tick(10);
      cont = 1'b0;
      tick(8);
      nvec++;
      if (run !== 1'b0) begin
         nerr++;
         $display("FAIL freerun_stop got %b want 0", run);
      end
      tick(10);
   endtask

   task automatic press(input bit do_inc, input bit do_dec, input int hold);
      inc = do_inc;
      dec = do_dec;
      tick(hold);
      inc = 1'b0;
      dec = 1'b0;
      tick(14);
   endtask

   task automatic test_wrap;
      press(1'b0, 1'b1, 8);
      nvec++;
      if (addr !== 8'hFF) begin
         nerr++;
         $display("FAIL wrap_dec got %h want FF", addr);
      end
      press(1'b1, 1'b0, 8);
      nvec++;
      if (addr !== 8'h00) begin
         nerr++;
         $display("FAIL wrap_inc got %h want 00", addr);
      end
      press(1'b1, 1'b1, 8);
      nvec++;
      if (addr !== 8'h00) begin
         nerr++;
         $display("FAIL inc_dec_same got %h want 00", addr);
      end
   endtask

   task automatic test_hold;
`ifdef DDU_AUTOREPEAT_EN
      // first pulse, repeats at edges 38,42..106 while held level persists
      exp_addr = 8'h13;
`else
      exp_addr = 8'h01;
`endif
      press(1'b1, 1'b0, 100);
      nvec++;
      if (addr !== exp_addr) begin
         nerr++;
         $display("FAIL hold_inc got %h want %h", addr, exp_addr);
      end
   endtask

   task automatic test_display;
      bit got0;
      bit got7;
      logic [7:0] pcs;
      reg_data = 32'h1234ABCD;
      mem_data = 32'h0;
      pc = 32'h0000_0104;
      mem = 1'b0;
      tick(2);
      pcs = 8'h41;
      nvec++;
      if (led !== {exp_addr, pcs}) begin
         nerr++;
         $display("FAIL led got %h want %h", led, {exp_addr, pcs});
      end
      got0 = 1'b0;
      got7 = 1'b0;
      for (int k = 0; k < 80; k++) begin
         tick(1);
         if (an === 8'hFE && !got0) begin
            got0 = 1'b1;
            nvec++;
            if (seg !== 7'h21) begin
               nerr++;
               $display("FAIL digit0_seg got %h want 21", seg);
            end
         end
         if (an === 8'h7F && !got7) begin
            got7 = 1'b1;
            nvec++;
            if (seg !== 7'h79) begin
               nerr++;
               $display("FAIL digit7_seg got %h want 79", seg);
            end
         end
      end
      nvec++;
      if (!(got0 && got7)) begin
         nerr++;
         $display("FAIL scan_timeout got %b%b want 11", got0, got7);
      end
      mem = 1'b1;
      tick(10);
      for (int k = 0; k < 40; k++) begin
         tick(1);
         nvec++;
         if (seg !== 7'h40) begin
            nerr++;
            $display("FAIL mem_zero_seg an=%h got %h want 40", an, seg);
         end
      end
   endtask

   initial begin
      test_reset();
      test_step();
      test_bounce();
      test_reset_mid_press();
      test_free_run();
      test_wrap();
      test_hold();
      test_display();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
